// File: rtl/dmem_pkg.sv
// Package for the byte-lane data memory: access-size encodings and the
// byte-enable helper shared by the lane-alignment logic.
package dmem_pkg;

    // Access size as presented on req_size
    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    // Byte-enable mask for an access of the given size at byte offset off.
    // Callers pass an offset that is already aligned for the size.
    function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            SZ_B:    mask = 4'b0001 << off;
            SZ_H:    mask = 4'b0011 << off;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane alignment for the byte-lane data memory.
// Store path: size/offset/data -> byte enables and lane-shifted write data.
// Load path: memory word -> lane-extracted, sign/zero-extended result.
// Build option: DMEM_MISALIGN_TRAP_EN turns misaligned and reserved-size
// accesses into faults; without it they are forced aligned / treated as word.
module dmem_lane_align (
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        fault
);
    import dmem_pkg::*;

    logic [1:0]  eff_size;
    logic [1:0]  eff_off;
    logic [31:0] shifted;

    // Decide the effective size/offset and whether the access faults
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        eff_size = size;
        eff_off  = off;
        fault    = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        fault = ((size == SZ_H) && off[0]) ||
                ((size == SZ_W) && (off != 2'b00)) ||
                (size == SZ_RSV);
`else
        if (size == SZ_RSV) begin
            eff_size = SZ_W;
        end
        if (eff_size == SZ_H) begin
            eff_off[0] = 1'b0;
        end else if (eff_size == SZ_W) begin
            eff_off = 2'b00;
        end
`endif
    end

    // Store lanes and load extraction/extension; a fault kills both
    always_comb begin
        be         = fault ? 4'b0000 : be_mask(eff_size, eff_off);
        wdata_lane = wdata << {eff_off, 3'b000};
        shifted    = rdata_word >> {eff_off, 3'b000};
        case (eff_size)
            SZ_B:    rdata_ext = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata_ext = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
        if (fault) begin
            rdata_ext = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_byte_lane.sv
// Byte-addressed single-port data memory for the LSU with byte/half/word
// accesses, valid/ready request channel and a registered, back-pressurable
// response. Build option: DMEM_MISALIGN_TRAP_EN (see dmem_lane_align).
module dmem_byte_lane #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    import dmem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic [3:0]       be;
    logic [31:0]      wdata_lane;
    logic [31:0]      rdata_ext;
    logic             fault;

    // Address bits above the array are deliberately ignored (index wraps)
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];

    // One outstanding response; a draining response frees the slot the same cycle
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[IDX_W+1:2];

    dmem_lane_align u_align (
        .size        (req_size),
        .off         (req_addr[1:0]),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .rdata_word  (mem[idx]),
        .be          (be),
        .wdata_lane  (wdata_lane),
        .rdata_ext   (rdata_ext),
        .fault       (fault)
    );

    // Per-byte store into the array on the accept edge
    // NOTE: the array has no reset so it maps onto plain RAM; its contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (accept && req_we && be[b]) begin
                mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

    // Response register: load on accept, drop valid on consume, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rsp_valid <= 1'b1;
            rsp_rdata <= req_we ? 32'h0 : rdata_ext;
            rsp_err   <= fault;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_byte_lane.sv
// Self-checking bench for dmem_byte_lane: scoreboard of expected responses,
// pushed when a request is accepted and popped by a response monitor.
module tb_dmem_byte_lane;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    dmem_byte_lane #(.DEPTH_WORDS(256), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Response monitor: samples mid low phase, compares against the scoreboard
    always @(negedge clk) begin
        #2;
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                             rsp_rdata, rsp_err, e.rdata, e.err);
                end
                if (e.lat) begin
                    checks++;
                    if (cycle !== e.cyc) begin
                        errors++;
                        $display("FAIL rsp_latency: got cycle %0d, required cycle %0d", cycle, e.cyc);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Present one request, wait (bounded) for acceptance, record the expected response
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit lat);
        int waited;
        exp_t e;
        @(negedge clk);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        waited       = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: req_ready stayed 0, required 1 within 20 cycles");
            req_valid = 1'b0;
            return;
        end
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cycle + 1;
        e.lat   = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected response has been seen
    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_unsigned = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", rsp_valid); end
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", rsp_err); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", rsp_rdata); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", req_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        send(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 32'h0, 1'b0, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_extend();
        send(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, 32'h0, 1'b0, 1'b1);
        send(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
        send(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h00000080, 1'b0, 1'b1);
        send(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 1'b1);
        send(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h00007F01, 1'b0, 1'b1);
        send(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0000007F, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        // Half store then immediate loads of the same word
        send(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, 32'h0, 1'b0, 1'b1);
        send(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000ABCD, 32'h0, 1'b0, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hABCD3344, 1'b0, 1'b1);
        send(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'hFFFFABCD, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        rsp_ready = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 1'b0);
        held = rsp_rdata;
        @(negedge clk);
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h10;
        req_wdata = 32'hFFFFFFFF;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 3;
            if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", rsp_valid); end
            if (rsp_rdata !== held) begin errors++; $display("FAIL bp_stable: got %h, required %h", rsp_rdata, held); end
            if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b, required 0", req_ready); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_wrap();
        send(1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678, 32'h0, 1'b0, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h12345678, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
        send(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1);
        send(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1);
        send(1'b1, 2'b10, 1'b0, 32'h13, 32'hA5A5A5A5, 32'h0, 1'b1, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1);
`else
        send(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1);
        send(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1);
        send(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h0000DEAD, 1'b0, 1'b1);
        send(1'b1, 2'b10, 1'b0, 32'h13, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1);
`endif
        drain();
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b0;
        send(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b, required 0", rsp_valid); end
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        send(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extend();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_misalign();
        test_reset_midflight();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
